synch_cdc: RTL and testbench
============================

# synch_cdc

Parameterised multi-flop clock-domain-crossing synchroniser for the async FIFO. It carries a multi-bit value, normally a Gray-coded read or write pointer, from the source domain into the `clk` domain through a chain of `STAGES` registers. It flags when the synchronised value changes, and can optionally detect illegal multi-bit (non-Gray) transitions. One instance sits in each direction: write pointer into the read domain, and read pointer into the write domain.

## Interface
Parameters:
- `data_width`, default 8: width of the synchronised bus.
- `STAGES`, default 2: number of flops in the chain. Legal minimum is 2; any value below 2 must cause an elaboration error.
- `RESET_VALUE`, default 0: value loaded into every stage on reset, width `data_width`.

Ports:
- `clk`, input, 1: destination-domain clock. All flops are rising-edge.
- `rst`, input, 1: asynchronous, active-low reset. Assertion takes effect immediately; release is sampled on `clk`.
- `data`, input, `data_width`: asynchronous source value, typically a Gray pointer.
- `data_out`, output, `data_width`: synchronised value, taken from the last stage.
- `changed`, output, 1: one-cycle pulse, high in the cycle in which `data_out` takes a new value.
- `gray_err`, output, 1: one-cycle pulse, high when `data_out` changes in more than one bit. Tied to 0 when the check is compiled out.

## Operation
- Chain: `stage[0] <= data`; then `stage[i] <= stage[i-1]` for i = 1..STAGES-1; `data_out = stage[STAGES-1]`.
- No combinational path from `data` to any output. `data` feeds only `stage[0]`.
- `changed` is registered: it captures `stage[STAGES-2] != stage[STAGES-1]` on the same edge at which `stage[STAGES-1]` loads `stage[STAGES-2]`. This keeps it aligned with the `data_out` update.
- `gray_err` is registered on the same edge: popcount(`stage[STAGES-2] ^ stage[STAGES-1]`) > 1.
- Arithmetic: the XOR and popcount are sized to `data_width`. The popcount is computed without overflow for any `data_width` up to 64.
- Values are transferred verbatim, with no encoding or decoding. Gray conversion belongs to the FIFO pointer logic.

## Timing
- Reset (`rst`=0): all stages = `RESET_VALUE`, `data_out` = `RESET_VALUE`, `changed` = 0, `gray_err` = 0. This applies immediately and asynchronously, including mid-transfer; any in-flight value is discarded.
- Latency: a `data` change settled before rising edge k appears on `data_out` after edge k+STAGES-1. That is 2 edges for the default configuration.
- `changed` and `gray_err` are valid in the same cycle as the new `data_out`. Each lasts exactly 1 cycle per change.
- If `data` changes every cycle, `data_out` follows every cycle delayed by STAGES edges. In that case `changed` stays high continuously.
- When `data` is constant, `changed` = 0 from STAGES cycles after the last change onward.
- First edge after reset release: stages shift normally. There is no extra blanking.
- An unknown or metastable `stage[0]` is tolerated by design. Outputs are defined only once `data` has been stable for one full cycle.

## Configuration
- Macro `SYNCH_GRAY_CHECK_EN`.
- Defined: the `gray_err` logic (XOR, popcount, flop) is built as described above.
- Undefined: no check logic is built, and `gray_err` is a constant 0. `data_out` and `changed` are unaffected.

## Test plan
- Reset: hold `rst`=0 for 5 cycles with `data`=8'hA5 and `RESET_VALUE`=0. Required: `data_out`=8'h00, `changed`=0, `gray_err`=0 throughout.
- Latency: release reset, set `data`=0, then change to 1 between edges. Required: `data_out`=1 exactly 2 edges later, with a single-cycle `changed` pulse aligned to it and `gray_err`=0.
- Multi-bit jump: with `SYNCH_GRAY_CHECK_EN` defined, change `data` from 8'h00 to 8'h03. Required: `data_out`=8'h03 after 2 edges, `changed`=1 and `gray_err`=1 for one cycle. With the macro undefined, `gray_err` stays 0.
- Gray count: drive the 8-bit Gray sequence 0,1,3,2,6,... one value per cycle. Required: `data_out` reproduces the sequence delayed 2 cycles, `changed` is high continuously, and `gray_err` is never set.
- Mid-transfer reset: change `data` to 8'h55, then assert `rst` one cycle later. Required: `data_out` = `RESET_VALUE` immediately, with no `changed` pulse. After release, 8'h55 appears 2 edges later.
- `STAGES`=3: a step on `data` appears on `data_out` after 3 edges, and `changed` is aligned to that update.

Source files
------------

// File: rtl/synch_cdc.sv
// Multi-flop synchroniser that carries a (normally Gray-coded) bus into the clk domain.
// Optional multi-bit transition check is enabled by defining SYNCH_GRAY_CHECK_EN.
module synch_cdc #(
    parameter int                    data_width  = 8,
    parameter int                    STAGES      = 2,
    parameter logic [data_width-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] data,
    output logic [data_width-1:0] data_out,
    output logic                  changed,
    output logic                  gray_err
);

    localparam int LAST = STAGES - 1;
    localparam int PREV = (STAGES >= 2) ? STAGES - 2 : 0;

    generate
        if (STAGES < 2) begin : g_stages_illegal
            $error("synch_cdc: STAGES must be at least 2");
        end
    endgenerate

    logic [data_width-1:0] stage_q [STAGES];
    logic [data_width-1:0] stage_d [STAGES];
    logic                  changed_q;
    logic                  changed_d;

    // stage[0] is the only flop that sees the asynchronous input.
    always_comb begin
        stage_d[0] = data;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stage_q[gi] <= RESET_VALUE;
                end else begin
                    stage_q[gi] <= stage_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        changed_d = (stage_q[PREV] != stage_q[LAST]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign data_out = stage_q[LAST];
    assign changed  = changed_q;

`ifdef SYNCH_GRAY_CHECK_EN
    localparam int POP_W = $clog2(data_width + 1);

    logic [data_width-1:0] diff;
    logic [POP_W-1:0]      pop;
    logic                  gray_err_q;
    logic                  gray_err_d;

    // Flags any update of data_out that flips more than one bit.
    always_comb begin
        diff = stage_q[PREV] ^ stage_q[LAST];
        pop  = '0;
        for (int i = 0; i < data_width; i++) begin
            pop = pop + POP_W'(diff[i]);
        end
        gray_err_d = (pop > POP_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gray_err_q <= 1'b0;
        end else begin
            gray_err_q <= gray_err_d;
        end
    end

    assign gray_err = gray_err_q;
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_synch_cdc.sv
// Self-checking bench for synch_cdc: a 2-stage and a 3-stage instance against a history-queue model.
module tb_synch_cdc;

`ifdef SYNCH_GRAY_CHECK_EN
    localparam bit GCHK = 1'b1;
`else
    localparam bit GCHK = 1'b0;
`endif
    localparam logic [7:0] RV1 = 8'h00;
    localparam logic [7:0] RV2 = 8'h3C;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [7:0] out1, out2;
    logic       chg1, chg2, err1, err2;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    bit  chk_en    = 1'b0;

    always #5 clk = ~clk;

    synch_cdc #(.data_width(8), .STAGES(2), .RESET_VALUE(RV1)) dut1 (
        .clk(clk), .rst(rst), .data(data),
        .data_out(out1), .changed(chg1), .gray_err(err1)
    );

    synch_cdc #(.data_width(8), .STAGES(3), .RESET_VALUE(RV2)) dut2 (
        .clk(clk), .rst(rst), .data(data),
        .data_out(out2), .changed(chg2), .gray_err(err2)
    );

    // Model: output is the input sampled STAGES edges ago; flags compare new vs old output.
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] m_out1, m_out2, old_v;
    logic       m_chg1, m_chg2, m_err1, m_err2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1 = {RV1, RV1};
            q2 = {RV2, RV2, RV2};
            m_out1 = RV1; m_out2 = RV2;
            m_chg1 = 1'b0; m_chg2 = 1'b0; m_err1 = 1'b0; m_err2 = 1'b0;
        end else begin
            old_v = m_out1;
            q1.push_front(data);
            void'(q1.pop_back());
            m_out1 = q1[1];
            m_chg1 = (m_out1 != old_v);
            m_err1 = GCHK && ($countones(m_out1 ^ old_v) > 1);
            old_v = m_out2;
            q2.push_front(data);
            void'(q2.pop_back());
            m_out2 = q2[2];
            m_chg2 = (m_out2 != old_v);
            m_err2 = GCHK && ($countones(m_out2 ^ old_v) > 1);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("s2_data_out", out1, m_out1);
            check("s2_changed", {7'b0, chg1}, {7'b0, m_chg1});
            check("s2_gray_err", {7'b0, err1}, {7'b0, m_err1});
            check("s3_data_out", out2, m_out2);
            check("s3_changed", {7'b0, chg2}, {7'b0, m_chg2});
            check("s3_gray_err", {7'b0, err2}, {7'b0, m_err2});
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    initial begin
        logic [7:0] g;
        rst  = 1'b1;
        data = 8'hA5;
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;

        // Reset held with a live input
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_out", out1, 8'h00);
            check("rst_changed", {7'b0, chg1}, 8'h00);
            check("rst_gray_err", {7'b0, err1}, 8'h00);
            check("rst_out_s3", out2, 8'h3C);
        end

        // Latency of a single-bit step
        rst  = 1'b1;
        data = 8'h00;
        tick(); tick(); tick();
        data = 8'h01;
        tick();
        check("lat_edge1_out", out1, 8'h00);
        check("lat_edge1_chg", {7'b0, chg1}, 8'h00);
        tick();
        check("lat_edge2_out", out1, 8'h01);
        check("lat_edge2_chg", {7'b0, chg1}, 8'h01);
        check("lat_edge2_err", {7'b0, err1}, 8'h00);
        tick();
        check("lat_edge3_chg", {7'b0, chg1}, 8'h00);
        check("lat_edge3_out", out1, 8'h01);

        // Multi-bit jump
        data = 8'h00;
        tick(); tick(); tick();
        data = 8'h03;
        tick(); tick();
        check("jump_out", out1, 8'h03);
        check("jump_chg", {7'b0, chg1}, 8'h01);
        check("jump_err", {7'b0, err1}, {7'b0, GCHK});
        tick();
        check("jump_err_clear", {7'b0, err1}, 8'h00);

        // Three-stage latency
        data = 8'h00;
        tick(); tick(); tick(); tick();
        data = 8'h81;
        tick(); tick();
        check("s3_edge2_out", out2, 8'h00);
        tick();
        check("s3_edge3_out", out2, 8'h81);
        check("s3_edge3_chg", {7'b0, chg2}, 8'h01);

        // Gray count, one value per cycle
        for (int i = 0; i < 40; i++) begin
            g = 8'(i) ^ (8'(i) >> 1);
            data = g;
            tick();
        end
        check("gray_tail_out", out1, 8'h35);
        check("gray_tail_chg", {7'b0, chg1}, 8'h01);

        // Reset during a transfer
        data = 8'h55;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out", out1, 8'h00);
        check("midrst_chg", {7'b0, chg1}, 8'h00);
        check("midrst_out_s3", out2, 8'h3C);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_edge1", out1, 8'h00);
        tick();
        check("post_rst_edge2", out1, 8'h55);
        check("post_rst_chg", {7'b0, chg1}, 8'h01);

        // Randomised mix of holds, Gray steps, arbitrary jumps and occasional resets
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ;
                3, 4, 5: data = data ^ (8'h01 << $urandom_range(0, 7));
                6, 7, 8: data = 8'($urandom);
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b0;
                        tick();
                        rst = 1'b1;
                    end
                end
            endcase
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
